// File: rtl/pair_sched_pkg.sv
// -----------------------------------------------------------------------------
// pair_sched_pkg
// Shared types and helpers for the pair sweep scheduler slice.
//   - sched_state_e : sweep controller states
//   - DEF_*         : default lane count, index width, area width, credit limit
//   - lane_mask()   : lane-enable mask for a work item (lane k live iff j+k < N)
// -----------------------------------------------------------------------------
package pair_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    localparam int DEF_NUM_LANES    = 8;
    localparam int DEF_IDX_W        = 16;
    localparam int DEF_AREA_W       = 64;
    localparam int DEF_MAX_INFLIGHT = 16;

    // Widest lane mask the helper can build; callers truncate to their lane count.
    localparam int MASK_MAX_W = 64;

    // Lane k of an item based at j is live when j+k is still a valid point
    // index. The sum is done one bit wider so j near the top of the index
    // range cannot wrap around and look valid.
    function automatic logic [MASK_MAX_W-1:0] lane_mask(
        input logic [31:0] n,
        input logic [31:0] j,
        input int          lanes
    );
        logic [MASK_MAX_W-1:0] m;
        m = '0;
        for (int k = 0; k < MASK_MAX_W; k++) begin
            if ((k < lanes) && (({1'b0, j} + 33'(k)) < {1'b0, n})) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pair_index_walker.sv
// -----------------------------------------------------------------------------
// pair_index_walker
// Walks the unordered pairs (i, j), j > i, of an N-point list in work items of
// one i and NUM_LANES consecutive j's starting at a base j.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   init_i       : restart the walk at (0, 1)
//   advance_i    : current item was accepted, move to the next one
//   n_i          : point count N of the current sweep
//   i_o, j_o     : current item's i index and base j index
//   mask_o       : lane k set iff j_o+k < N
//   last_o       : current item is the final item of the sweep
// -----------------------------------------------------------------------------
module pair_index_walker
    import pair_sched_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_i,
    input  logic                 advance_i,
    input  logic [IDX_W-1:0]     n_i,
    output logic [IDX_W-1:0]     i_o,
    output logic [IDX_W-1:0]     j_o,
    output logic [NUM_LANES-1:0] mask_o,
    output logic                 last_o
);

    localparam logic [IDX_W:0] LANES_X = (IDX_W + 1)'(NUM_LANES);
    localparam logic [IDX_W:0] TWO_X   = (IDX_W + 1)'(2);

    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic             moreJ;
    logic             moreI;

    // Comparisons are one bit wider than the index so N near the top of the
    // index range and small N (0, 1) both compare correctly.
    assign moreJ = ({1'b0, j_q} + LANES_X) < {1'b0, n_i};
    assign moreI = ({1'b0, i_q} + TWO_X) < {1'b0, n_i};

    // When the current row of j's is exhausted the next row starts at the
    // first j after the new i, which is the old i plus two.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (init_i) begin
            i_d = '0;
            j_d = IDX_W'(1);
        end else if (advance_i) begin
            if (moreJ) begin
                j_d = j_q + IDX_W'(NUM_LANES);
            end else if (moreI) begin
                i_d = i_q + IDX_W'(1);
                j_d = i_q + IDX_W'(2);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign i_o    = i_q;
    assign j_o    = j_q;
    assign mask_o = NUM_LANES'(lane_mask(32'(n_i), 32'(j_q), NUM_LANES));
    assign last_o = !moreJ && !moreI;

endmodule

// File: rtl/pair_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// pair_sweep_scheduler
// Sequences one sweep of the pairwise rectangle-area engine array: issues every
// (i, base j) work item over a valid/ready handshake, limits in-flight items by
// credit, and reduces the per-item maxima returned by the engines to a global
// maximum.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, num_points   : level start request (sampled in IDLE), point count N
//   busy, finished      : sweep running (ISSUE/DRAIN), sweep complete (DONE)
//   result              : global max area, valid while finished
//   err                 : sticky, a return arrived with nothing outstanding
//   iss_valid/ready     : work item handshake
//   iss_i, iss_j        : item i index and base j index
//   iss_mask            : lane k set iff iss_j+k < N
//   ret_valid, ret_area : one per-item max per accepted item, in order
// Optional (macro PAIR_SCHED_STATS_EN):
//   stat_items          : handshakes this sweep
//   stat_stall          : ISSUE cycles without a handshake (ready or credit stall)
// -----------------------------------------------------------------------------
module pair_sweep_scheduler
    import pair_sched_pkg::*;
#(
    parameter int NUM_LANES    = DEF_NUM_LANES,
    parameter int IDX_W        = DEF_IDX_W,
    parameter int AREA_W       = DEF_AREA_W,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IDX_W-1:0]     num_points,
    output logic                 busy,
    output logic                 finished,
    output logic [AREA_W-1:0]    result,
    output logic                 err,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic [IDX_W-1:0]     iss_i,
    output logic [IDX_W-1:0]     iss_j,
    output logic [NUM_LANES-1:0] iss_mask,
    input  logic                 ret_valid,
    input  logic [AREA_W-1:0]    ret_area
`ifdef PAIR_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_items,
    output logic [31:0]          stat_stall
`endif
);

    localparam int              CNT_W        = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] CREDIT_LIMIT = CNT_W'(MAX_INFLIGHT);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [AREA_W-1:0] max_q, max_d;
    logic             err_q, err_d;

    logic startAcc;
    logic creditOk;
    logic handshake;
    logic retOk;
    logic retBad;
    logic walkLast;

    assign startAcc  = (state_q == ST_IDLE) && start;
    assign creditOk  = outstanding_q < CREDIT_LIMIT;
    assign handshake = iss_valid && iss_ready;
    assign retOk     = ret_valid && (outstanding_q != '0);
    assign retBad    = ret_valid && (outstanding_q == '0);

    pair_index_walker #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_walker (
        .clk       (clk),
        .rst       (rst),
        .init_i    (startAcc),
        .advance_i (handshake),
        .n_i       (n_q),
        .i_o       (iss_i),
        .j_o       (iss_j),
        .mask_o    (iss_mask),
        .last_o    (walkLast)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN looks at the post-update outstanding count so a return in the
    // same cycle as the count reaching zero still lands in the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_points < IDX_W'(2)) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (handshake && walkLast) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outstanding_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        finished  = 1'b0;
        iss_valid = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                busy      = 1'b1;
                iss_valid = creditOk;
            end
            ST_DRAIN: busy     = 1'b1;
            ST_DONE:  finished = 1'b1;
            default:  ;
        endcase
    end

    // A return with nothing outstanding is a datapath protocol error: it is
    // flagged and otherwise ignored so it cannot underflow the credit count
    // or pollute the maximum.
    always_comb begin
        n_d           = n_q;
        outstanding_d = outstanding_q;
        max_d         = max_q;
        err_d         = err_q;
        if (startAcc) begin
            n_d   = num_points;
            max_d = '0;
            err_d = 1'b0;
        end
        if (handshake && !retOk) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!handshake && retOk) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
        if (retOk && (ret_area > max_q)) begin
            max_d = ret_area;
        end
        if (retBad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q           <= '0;
            outstanding_q <= '0;
            max_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            n_q           <= n_d;
            outstanding_q <= outstanding_d;
            max_q         <= max_d;
            err_q         <= err_d;
        end
    end

    assign result = max_q;
    assign err    = err_q;

`ifdef PAIR_SCHED_STATS_EN
    logic [31:0] statItems_q, statItems_d;
    logic [31:0] statStall_q, statStall_d;

    // Counting only happens in ISSUE, so both counters freeze once the sweep
    // leaves it and hold through DONE.
    always_comb begin
        statItems_d = statItems_q;
        statStall_d = statStall_q;
        if (startAcc) begin
            statItems_d = '0;
            statStall_d = '0;
        end else if (state_q == ST_ISSUE) begin
            if (handshake) begin
                statItems_d = statItems_q + 32'd1;
            end else begin
                statStall_d = statStall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            statItems_q <= '0;
            statStall_q <= '0;
        end else begin
            statItems_q <= statItems_d;
            statStall_q <= statStall_d;
        end
    end

    assign stat_items = statItems_q;
    assign stat_stall = statStall_q;
`endif

endmodule

// File: tb/tb_pair_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pair_sweep_scheduler
// Self-checking bench for pair_sweep_scheduler. Expected work items come from a
// plain nested loop over (i, j) pairs, the item count from the ceil-sum
// formula, and the result from the maximum of the areas the bench returned.
// -----------------------------------------------------------------------------
module tb_pair_sweep_scheduler;

    localparam int NL   = 8;
    localparam int IW   = 16;
    localparam int AW   = 64;
    localparam int MAXF = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [IW-1:0] num_points;
    logic          busy;
    logic          finished;
    logic [AW-1:0] result;
    logic          err;
    logic          iss_valid;
    logic          iss_ready;
    logic [IW-1:0] iss_i;
    logic [IW-1:0] iss_j;
    logic [NL-1:0] iss_mask;
    logic          ret_valid;
    logic [AW-1:0] ret_area;
`ifdef PAIR_SCHED_STATS_EN
    logic [31:0]   stat_items;
    logic [31:0]   stat_stall;
`endif

    int checks = 0;
    int passed = 0;
    logic [AW-1:0] fixedAreas[$];

    pair_sweep_scheduler #(
        .NUM_LANES    (NL),
        .IDX_W        (IW),
        .AREA_W       (AW),
        .MAX_INFLIGHT (MAXF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_points (num_points),
        .busy       (busy),
        .finished   (finished),
        .result     (result),
        .err        (err),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_i      (iss_i),
        .iss_j      (iss_j),
        .iss_mask   (iss_mask),
        .ret_valid  (ret_valid),
        .ret_area   (ret_area)
`ifdef PAIR_SCHED_STATS_EN
        ,
        .stat_items (stat_items),
        .stat_stall (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset values of every output while reset is held.
    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b0;
        num_points = '0;
        iss_ready  = 1'b0;
        ret_valid  = 1'b0;
        ret_area   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, finished, err, iss_valid} !== 4'b0000 || result !== '0 ||
            iss_i !== '0 || iss_j !== '0 || iss_mask !== '0) begin
            $display("[TB] FAIL reset_values: got busy=%b fin=%b err=%b valid=%b res=%0d i=%0d j=%0d mask=%h want all zero",
                     busy, finished, err, iss_valid, result, iss_i, iss_j, iss_mask);
        end else passed++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One full sweep of N points against the reference model. readyPct and
    // retPct set the chance per cycle of iss_ready and of a due return being
    // presented; maxDelay bounds extra return latency.
    task automatic test_sweep(input int n, input int readyPct, input int retPct, input int maxDelay);
        int            expI[$];
        int            expJ[$];
        logic [NL-1:0] expM[$];
        logic [AW-1:0] pendArea[$];
        int            pendTime[$];
        int            total;
        int            issued;
        int            outs;
        logic [AW-1:0] modelMax;
        logic [AW-1:0] area;
        logic          hsPend;
        logic          retPend;
        logic          prevStall;
        logic [IW-1:0] savedI;
        logic [IW-1:0] savedJ;
        logic [NL-1:0] savedM;
        logic          expFin;
        logic          expValid;
        logic          done;
        logic [NL-1:0] m;
        int            sel;

        total = 0;
        for (int i = 0; i <= n - 2; i++) begin
            total += ((n - 1 - i) + NL - 1) / NL;
            for (int j = i + 1; j < n; j += NL) begin
                for (int k = 0; k < NL; k++) m[k] = (j + k < n);
                expI.push_back(i);
                expJ.push_back(j);
                expM.push_back(m);
            end
        end

        issued    = 0;
        outs      = 0;
        modelMax  = '0;
        hsPend    = 1'b0;
        retPend   = 1'b0;
        prevStall = 1'b0;
        savedI    = '0;
        savedJ    = '0;
        savedM    = '0;
        done      = 1'b0;
        start      = 1'b1;
        num_points = IW'(n);
        iss_ready  = 1'b0;
        ret_valid  = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            if (hsPend) begin
                issued++;
                outs++;
            end
            if (retPend) outs--;
            hsPend  = 1'b0;
            retPend = 1'b0;
            num_points = IW'($urandom);

            expFin   = (issued >= total) && (outs == 0);
            expValid = (issued < total) && (outs < MAXF);
            checks++;
            if (finished !== expFin || busy !== !expFin || iss_valid !== expValid) begin
                $display("[TB] FAIL sweep_ctrl n=%0d cyc=%0d: got fin=%b busy=%b valid=%b want fin=%b busy=%b valid=%b",
                         n, cyc, finished, busy, iss_valid, expFin, !expFin, expValid);
            end else passed++;
            if (expFin) begin
                done = 1'b1;
                break;
            end

            if (prevStall && iss_valid) begin
                checks++;
                if (iss_i !== savedI || iss_j !== savedJ || iss_mask !== savedM) begin
                    $display("[TB] FAIL stall_stable n=%0d: got i=%0d j=%0d mask=%h want i=%0d j=%0d mask=%h",
                             n, iss_i, iss_j, iss_mask, savedI, savedJ, savedM);
                end else passed++;
            end

            iss_ready = ($urandom_range(99) < readyPct);
            if (iss_valid && iss_ready) begin
                hsPend = 1'b1;
                checks++;
                if (issued >= total) begin
                    $display("[TB] FAIL sweep_item n=%0d: got extra item i=%0d j=%0d want no item",
                             n, iss_i, iss_j);
                end else if (iss_i !== IW'(expI[issued]) || iss_j !== IW'(expJ[issued]) ||
                             iss_mask !== expM[issued]) begin
                    $display("[TB] FAIL sweep_item n=%0d #%0d: got i=%0d j=%0d mask=%h want i=%0d j=%0d mask=%h",
                             n, issued, iss_i, iss_j, iss_mask, expI[issued], expJ[issued], expM[issued]);
                end else passed++;
                if (fixedAreas.size() > 0) begin
                    area = fixedAreas.pop_front();
                end else begin
                    sel = $urandom_range(3);
                    case (sel)
                        0:       area = AW'($urandom_range(50));
                        1:       area = {$urandom, $urandom};
                        2:       area = {1'b1, 31'($urandom), 32'($urandom)};
                        default: area = '0;
                    endcase
                end
                pendArea.push_back(area);
                pendTime.push_back(cyc + 1 + $urandom_range(maxDelay));
            end
            prevStall = iss_valid && !iss_ready;
            savedI    = iss_i;
            savedJ    = iss_j;
            savedM    = iss_mask;

            ret_valid = 1'b0;
            if (pendArea.size() > 0 && pendTime[0] <= cyc && $urandom_range(99) < retPct) begin
                ret_valid = 1'b1;
                ret_area  = pendArea.pop_front();
                void'(pendTime.pop_front());
                if (ret_area > modelMax) modelMax = ret_area;
                retPend = 1'b1;
            end
        end

        iss_ready = 1'b0;
        ret_valid = 1'b0;
        checks++;
        if (!done) begin
            $display("[TB] FAIL sweep_timeout n=%0d: got issued=%0d outstanding=%0d want finished within 4000 cycles",
                     n, issued, outs);
        end else passed++;

        checks++;
        if (issued !== total || result !== modelMax || err !== 1'b0) begin
            $display("[TB] FAIL sweep_result n=%0d: got items=%0d result=%h err=%b want items=%0d result=%h err=0",
                     n, issued, result, err, total, modelMax);
        end else passed++;
`ifdef PAIR_SCHED_STATS_EN
        checks++;
        if (stat_items !== 32'(total)) begin
            $display("[TB] FAIL stat_items n=%0d: got %0d want %0d", n, stat_items, total);
        end else passed++;
`endif

        // Start still high: DONE must hold without relaunching.
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (finished !== 1'b1 || busy !== 1'b0 || result !== modelMax) begin
            $display("[TB] FAIL done_hold n=%0d: got fin=%b busy=%b result=%h want fin=1 busy=0 result=%h",
                     n, finished, busy, result, modelMax);
        end else passed++;

        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (finished !== 1'b0 || busy !== 1'b0 || iss_valid !== 1'b0) begin
            $display("[TB] FAIL back_to_idle n=%0d: got fin=%b busy=%b valid=%b want 0 0 0",
                     n, finished, busy, iss_valid);
        end else passed++;
    endtask

    // Known-answer sweep: areas 6, 9, 2 returned one cycle after each issue.
    task automatic test_n4();
        fixedAreas.delete();
        fixedAreas.push_back(64'd6);
        fixedAreas.push_back(64'd9);
        fixedAreas.push_back(64'd2);
        test_sweep(4, 100, 100, 0);
        checks++;
        if (result !== 64'd9) begin
            $display("[TB] FAIL n4_result: got %0d want 9", result);
        end else passed++;
    endtask

    task automatic test_small_n();
        test_sweep(1, 100, 100, 0);
        test_sweep(0, 100, 100, 0);
    endtask

    // With returns withheld only MAXF items go out; one return buys exactly
    // one more item.
    task automatic test_credit();
        int hs;
        hs         = 0;
        start      = 1'b1;
        num_points = IW'(20);
        iss_ready  = 1'b1;
        ret_valid  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (iss_valid && iss_ready) hs++;
        end
        checks++;
        if (hs !== MAXF || iss_valid !== 1'b0) begin
            $display("[TB] FAIL credit_block: got handshakes=%0d valid=%b want %0d valid=0", hs, iss_valid, MAXF);
        end else passed++;

        ret_valid = 1'b1;
        ret_area  = 64'd5;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            ret_valid = 1'b0;
            if (iss_valid && iss_ready) hs++;
        end
        checks++;
        if (hs !== MAXF + 1 || iss_valid !== 1'b0 || busy !== 1'b1) begin
            $display("[TB] FAIL credit_release: got handshakes=%0d valid=%b busy=%b want %0d valid=0 busy=1",
                     hs, iss_valid, busy, MAXF + 1);
        end else passed++;
    endtask

    // Reset raised between clock edges must clear outputs immediately.
    task automatic test_async_reset();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, finished, err, iss_valid} !== 4'b0000 || result !== '0 ||
            iss_i !== '0 || iss_j !== '0 || iss_mask !== '0) begin
            $display("[TB] FAIL async_reset: got busy=%b fin=%b err=%b valid=%b res=%0d i=%0d j=%0d mask=%h want all zero",
                     busy, finished, err, iss_valid, result, iss_i, iss_j, iss_mask);
        end else passed++;
        iss_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_err_idle();
        ret_valid = 1'b1;
        ret_area  = 64'd77;
        @(posedge clk);
        #1;
        ret_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || result !== '0) begin
            $display("[TB] FAIL err_idle: got err=%b result=%0d want err=1 result=0", err, result);
        end else passed++;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1) begin
            $display("[TB] FAIL err_sticky: got err=%b want 1", err);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 6; s++) begin
            test_sweep($urandom_range(30, 2), $urandom_range(90, 30), $urandom_range(90, 30), $urandom_range(3));
        end
    endtask

    initial begin
        test_reset();
        test_n4();
        test_sweep(10, 100, 100, 0);
        test_small_n();
        test_credit();
        test_async_reset();
        test_err_idle();
        test_sweep(10, 50, 60, 2);
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
